// File: rtl/fifo_arb_pkg.sv
// Shared types and width helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int gnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin pick: the first requester after last_gnt wins, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GNT_W   = gnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GNT_W-1:0]   last_gnt,
  output logic [GNT_W-1:0]   winner,
  output logic               any_req
);

  int               idx;
  logic [GNT_W-1:0] sel;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    sel     = '0;
    // Offset 1 first so the previous owner gets lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_gnt) + k) % NUM_REQ;
      sel = GNT_W'(idx);
      if (!any_req && req[sel]) begin
        any_req = 1'b1;
        winner  = sel;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers,
// with bounded bursts and sticky checks on the FIFO write responses.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            wr_en,
  output logic [FIFO_WIDTH-1:0]           data_in,
  input  logic                            full,
  input  logic                            wr_ack,
  input  logic                            overflow,
  output logic [gnt_width(NUM_REQ)-1:0]   gnt_id,
  output logic                            busy,
  output logic                            err_overflow,
  output logic                            err_ack_miss
);

  localparam int GNT_W  = gnt_width(NUM_REQ);
  localparam int BEAT_W = gnt_width(MAX_BURST);

  arb_state_e       state;
  logic [GNT_W-1:0] last_gnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic             ack_pend;
  logic [GNT_W-1:0] pick_winner;
  logic             pick_any;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_picker (
    .req      (req_valid),
    .last_gnt (last_gnt),
    .winner   (pick_winner),
    .any_req  (pick_any)
  );

  // Write side is combinational so a full assertion stalls in the same cycle.
  always_comb begin
    wr_en     = 1'b0;
    req_ready = '0;
    data_in   = '0;
    if (state == ARB_BURST) begin
      req_ready[gnt_id] = ~full;
      wr_en             = req_valid[gnt_id] & ~full;
      data_in           = req_data[int'(gnt_id)*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  assign busy = (state == ARB_BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      last_gnt     <= GNT_W'(NUM_REQ - 1);
      gnt_id       <= '0;
      beat_cnt     <= '0;
      ack_pend     <= 1'b0;
      err_ack_miss <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      ack_pend <= wr_en;
      if (ack_pend && !wr_ack) err_ack_miss <= 1'b1;
      if (overflow)            err_overflow <= 1'b1;

      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            gnt_id   <= pick_winner;
            last_gnt <= pick_winner;
            beat_cnt <= '0;
            state    <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (wr_en) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BEAT_W'(MAX_BURST - 1)) state <= ARB_IDLE;
          end else if (!req_valid[gnt_id]) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producers and FIFO responses are modelled here.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        wr_en;
  logic [15:0] data_in;
  logic        full;
  logic        wr_ack;
  logic        overflow;
  logic [1:0]  gnt_id;
  logic        busy;
  logic        err_overflow;
  logic        err_ack_miss;

  int checks;
  int passes;
  int rem  [4];
  int sent [4];
  logic drop_ack;
  logic ovf_set;

  fifo_wr_arbiter #(
    .FIFO_WIDTH (16),
    .NUM_REQ    (4),
    .MAX_BURST  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .full         (full),
    .wr_ack       (wr_ack),
    .overflow     (overflow),
    .gnt_id       (gnt_id),
    .busy         (busy),
    .err_overflow (err_overflow),
    .err_ack_miss (err_ack_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_producers();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]         = (rem[i] > 0);
      req_data[i*16 +: 16] = 16'(i*4096 + sent[i]);
    end
  endtask

  // Called between negedge and posedge; advances producers and the FIFO response model.
  task automatic tick();
    logic [3:0] x;
    logic       w;
    x = req_valid & req_ready;
    w = wr_en;
    @(posedge clk);
    #1;
    wr_ack   = w & ~drop_ack;
    drop_ack = 1'b0;
    overflow = ovf_set;
    ovf_set  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (x[i]) begin
        sent[i] = sent[i] + 1;
        rem[i]  = rem[i] - 1;
      end
    end
    drive_producers();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    full     = 1'b0;
    wr_ack   = 1'b0;
    overflow = 1'b0;
    drop_ack = 1'b0;
    ovf_set  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rem[i]  = 0;
      sent[i] = 0;
    end
    drive_producers();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_data  = 64'h1234_5678_9abc_def0;
    full = 1'b0; wr_ack = 1'b0; overflow = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b need 0", busy); else passes++;
    checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b need 0", wr_en); else passes++;
    checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got %b need 0000", req_ready); else passes++;
    checks++; if (gnt_id !== 2'd0) $display("FAIL reset_gnt_id got %0d need 0", gnt_id); else passes++;
    checks++; if (data_in !== 16'h0000) $display("FAIL reset_data_in got %h need 0000", data_in); else passes++;
    checks++; if ({err_ack_miss, err_overflow} !== 2'b00) $display("FAIL reset_err got %b need 00", {err_ack_miss, err_overflow}); else passes++;
    do_reset();
  endtask

  task automatic test_single();
    logic [9:0] exp_wr;
    logic [9:0] exp_busy;
    int n;
    exp_wr   = 10'b0011011110;
    exp_busy = 10'b0111011110;
    n = 0;
    do_reset();
    rem[0] = 6;
    drive_producers();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (wr_en !== exp_wr[c]) $display("FAIL single_wr_en c%0d got %b need %b", c, wr_en, exp_wr[c]); else passes++;
      checks++; if (busy !== exp_busy[c]) $display("FAIL single_busy c%0d got %b need %b", c, busy, exp_busy[c]); else passes++;
      if (exp_wr[c]) begin
        checks++; if (data_in !== 16'(n)) $display("FAIL single_data c%0d got %h need %h", c, data_in, 16'(n)); else passes++;
        checks++; if (gnt_id !== 2'd0) $display("FAIL single_gnt c%0d got %0d need 0", c, gnt_id); else passes++;
      end
      if (wr_en === 1'b1) n++;
      tick();
    end
    checks++; if (n !== 6) $display("FAIL single_count got %0d need 6", n); else passes++;
  endtask

  task automatic test_round_robin();
    logic       ew;
    logic [3:0] er;
    int g, b, n;
    n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) rem[i] = 8;
    drive_producers();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      ew = (c % 5) != 0;
      g  = (c > 0) ? ((c - 1) / 5) % 4 : 0;
      b  = (c > 0) ? (c - 1) % 5 + ((c - 1) / 20) * 4 : 0;
      er = ew ? 4'(1 << g) : 4'b0000;
      checks++; if (wr_en !== ew) $display("FAIL rr_wr_en c%0d got %b need %b", c, wr_en, ew); else passes++;
      checks++; if (req_ready !== er) $display("FAIL rr_req_ready c%0d got %b need %b", c, req_ready, er); else passes++;
      if (ew) begin
        checks++; if (gnt_id !== 2'(g)) $display("FAIL rr_gnt c%0d got %0d need %0d", c, gnt_id, g); else passes++;
        checks++; if (data_in !== 16'(g*4096 + b)) $display("FAIL rr_data c%0d got %h need %h", c, data_in, 16'(g*4096 + b)); else passes++;
      end
      if (wr_en === 1'b1) n++;
      tick();
    end
    checks++; if (n !== 20) $display("FAIL rr_count got %0d need 20", n); else passes++;
    checks++; if ({err_ack_miss, err_overflow} !== 2'b00) $display("FAIL rr_err got %b need 00", {err_ack_miss, err_overflow}); else passes++;
  endtask

  task automatic test_full_stall();
    logic [8:0] exp_wr;
    logic [8:0] exp_busy;
    int n;
    exp_wr   = 9'b011000110;
    exp_busy = 9'b011111110;
    n = 0;
    do_reset();
    rem[0] = 4;
    drive_producers();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++; if (wr_en !== exp_wr[c]) $display("FAIL stall_wr_en c%0d got %b need %b", c, wr_en, exp_wr[c]); else passes++;
      checks++; if (req_ready !== (exp_wr[c] ? 4'b0001 : 4'b0000)) $display("FAIL stall_req_ready c%0d got %b", c, req_ready); else passes++;
      checks++; if (busy !== exp_busy[c]) $display("FAIL stall_busy c%0d got %b need %b", c, busy, exp_busy[c]); else passes++;
      if (exp_busy[c]) begin
        checks++; if (gnt_id !== 2'd0) $display("FAIL stall_gnt c%0d got %0d need 0", c, gnt_id); else passes++;
      end
      if (exp_wr[c]) begin
        checks++; if (data_in !== 16'(n)) $display("FAIL stall_data c%0d got %h need %h", c, data_in, 16'(n)); else passes++;
      end
      if (wr_en === 1'b1) n++;
      tick();
      full = (c >= 2 && c <= 4);
    end
    full = 1'b0;
  endtask

  task automatic test_early_release();
    do_reset();
    rem[1] = 2;
    rem[2] = 4;
    drive_producers();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1 || c == 2) begin
        checks++; if (gnt_id !== 2'd1 || wr_en !== 1'b1) $display("FAIL early_grant1 c%0d got gnt %0d wr %b need gnt 1 wr 1", c, gnt_id, wr_en); else passes++;
      end
      if (c == 3) begin
        checks++; if (wr_en !== 1'b0 || busy !== 1'b1) $display("FAIL early_drop c3 got wr %b busy %b need wr 0 busy 1", wr_en, busy); else passes++;
      end
      if (c == 4) begin
        checks++; if (busy !== 1'b0) $display("FAIL early_idle c4 got busy %b need 0", busy); else passes++;
      end
      if (c == 5) begin
        checks++; if (gnt_id !== 2'd2 || wr_en !== 1'b1 || data_in !== 16'h2000) $display("FAIL early_next c5 got gnt %0d wr %b data %h need gnt 2 wr 1 data 2000", gnt_id, wr_en, data_in); else passes++;
      end
      tick();
    end
  endtask

  task automatic test_errors();
    do_reset();
    rem[0] = 3;
    drive_producers();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 3) begin
        checks++; if (err_ack_miss !== 1'b0) $display("FAIL err_ack_early c3 got %b need 0", err_ack_miss); else passes++;
      end
      if (c >= 4) begin
        checks++; if (err_ack_miss !== 1'b1) $display("FAIL err_ack_set c%0d got %b need 1", c, err_ack_miss); else passes++;
      end
      if (c == 6) begin
        checks++; if (err_overflow !== 1'b0) $display("FAIL err_ovf_early c6 got %b need 0", err_overflow); else passes++;
      end
      if (c >= 7) begin
        checks++; if (err_overflow !== 1'b1) $display("FAIL err_ovf_set c%0d got %b need 1", c, err_overflow); else passes++;
      end
      if (c == 2) drop_ack = 1'b1;
      if (c == 5) ovf_set  = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({err_ack_miss, err_overflow} !== 2'b00) $display("FAIL err_clear got %b need 00", {err_ack_miss, err_overflow}); else passes++;
    do_reset();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rem[0] = 4;
    rem[1] = 4;
    drive_producers();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c < 2) tick();
    end
    checks++; if (wr_en !== 1'b1) $display("FAIL midrst_pre got wr %b need 1", wr_en); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0) $display("FAIL midrst_wr_en got %b need 0", wr_en); else passes++;
    checks++; if (req_ready !== 4'b0000) $display("FAIL midrst_req_ready got %b need 0000", req_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b need 0", busy); else passes++;
    repeat (2) @(posedge clk);
    #1;
    wr_ack = 1'b0;
    rst_n  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (busy !== 1'b0) $display("FAIL midrst_idle got busy %b need 0", busy); else passes++;
      end else begin
        checks++; if (gnt_id !== 2'd0 || wr_en !== 1'b1 || data_in !== 16'h0001) $display("FAIL midrst_regrant got gnt %0d wr %b data %h need gnt 0 wr 1 data 0001", gnt_id, wr_en, data_in); else passes++;
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    drop_ack = 1'b0;
    ovf_set  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rem[i]  = 0;
      sent[i] = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_errors();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write side of the synchronous FIFO between `NUM_REQ` producers. Each producer offers words on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO `wr_en`/`data_in`, never writing while `full`. It also checks the FIFO's `wr_ack`/`overflow` responses and flags protocol errors. It sits between the producer blocks and the FIFO write-side pins.

## Interface
- `FIFO_WIDTH`, 16, word width; matches the FIFO.
- `NUM_REQ`, 4, number of producers; 2..8.
- `MAX_BURST`, 4, maximum words per grant; 1..16.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: producer i has a word.
- `req_data` in NUM_REQ*FIFO_WIDTH: producer i's word at bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- `req_ready` out NUM_REQ: a word transfers when `req_valid[i] & req_ready[i]`.
- `wr_en` out 1: FIFO write enable.
- `data_in` out FIFO_WIDTH: FIFO write data.
- `full` in 1: FIFO full.
- `wr_ack` in 1: FIFO write acknowledge, the cycle after the write.
- `overflow` in 1: FIFO overflow, the cycle after a rejected write.
- `gnt_id` out $clog2(NUM_REQ): current grant owner; valid while `busy`.
- `busy` out 1: FSM is in ARB_BURST.
- `err_overflow` out 1: sticky; `overflow` was seen high.
- `err_ack_miss` out 1: sticky; a write was not acknowledged.

## Operation
- FSM states: ARB_IDLE, ARB_BURST.
- **ARB_IDLE**
  - If any `req_valid`, pick the winner by round-robin, starting at `last_gnt+1` and wrapping.
  - Register the winner as `gnt_id` and `last_gnt`, clear `beat_cnt`, go to ARB_BURST.
  - Otherwise stay in ARB_IDLE.
  - `full` does not block arbitration.
- **ARB_BURST** (g = `gnt_id`)
  - `wr_en = req_valid[g] & ~full`.
  - `req_ready[g] = ~full`; all other `req_ready` bits are 0.
  - `data_in` = slice g of `req_data`.
  - Each write increments `beat_cnt`.
  - Go to ARB_IDLE when a write occurs with `beat_cnt == MAX_BURST-1`, or when `req_valid[g]` is 0 (no write that cycle).
  - `full` high with `req_valid[g]` high: stall; hold the grant, do not write, do not count.
- `wr_en`, `req_ready`, `data_in` are combinational from the state, `gnt_id`, `req_valid` and `full`. `data_in` is 0 when not in ARB_BURST.
- **Response check**
  - `ack_pend` is a registered copy of `wr_en`.
  - `ack_pend & ~wr_ack` sets `err_ack_miss`.
  - `overflow` high sets `err_overflow`.
  - Both flags clear only on reset.
- **Reset values:** state ARB_IDLE; `last_gnt = NUM_REQ-1`, so requester 0 wins first; `gnt_id` 0; `beat_cnt` 0; `busy`, `wr_en`, `req_ready`, `ack_pend`, both error flags 0.
- **Reset mid-burst:** `wr_en` and `req_ready` drop immediately (asynchronous). No partial-burst state survives.

## Timing
- Grant latency: one cycle from `req_valid` in ARB_IDLE to the first possible write.
- One idle bubble between consecutive bursts, from the ARB_IDLE arbitration cycle.
- Sustained throughput: MAX_BURST words per MAX_BURST+1 cycles under contention.
- The producer must hold `req_valid`/data stable until ready; a `req_valid` drop ends the burst.
- `wr_en` is never high in a cycle where `full` is high.
- `full` rising mid-burst stalls within the same cycle. Writes resume the first cycle `full` is low.

## Structure
- Package `fifo_arb_pkg`: `arb_state_e` (ARB_IDLE, ARB_BURST) and a `clog2`-based `GNT_W` helper.
- Sub-module `rr_picker`: combinational round-robin priority pick. Inputs: request vector, last grant. Outputs: winner index, any-request flag.

## Test plan
- **Single producer.** `req_valid=4'b0001`, 6 words, FIFO empty. Expect: words 0-3 written back-to-back, one bubble, words 4-5 written; `gnt_id` 0 throughout.
- **Round-robin fairness.** All four valid continuously. Expect: grant order 0,1,2,3,0…; each burst exactly 4 `wr_en` pulses; 4 writes per 5 cycles.
- **Full stall.** Force `full` high for 3 cycles after beat 2 of a burst. Expect: `wr_en` 0 and `req_ready` 0 in those cycles, grant held, beats 3-4 written after `full` drops.
- **Early release.** Requester 1 drops `req_valid` after 2 words. Expect: returns to ARB_IDLE, next grant goes to requester 2.
- **Error flags.** FIFO model withholds one `wr_ack`, then pulses `overflow`. Expect: `err_ack_miss` rises the cycle after the missing ack, `err_overflow` the cycle after `overflow`; both stay high until `rst_n` is low.
- **Reset mid-burst.** Assert `rst_n=0` asynchronously at beat 2. Expect: `wr_en`/`req_ready` 0 immediately; after release, first grant goes to requester 0.
